// File: rtl/hack_mem_pkg.sv
// Shared widths and FSM state encoding for the RAM512 block mover.
package hack_mem_pkg;

    localparam int AW = 9;
    localparam int DW = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        FILL  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_block_mover_if.sv
// Command and RAM port bundle for mem_block_mover; slave is the mover side.
interface mem_block_mover_if #(
    parameter int AW = hack_mem_pkg::AW,
    parameter int DW = hack_mem_pkg::DW
);
    logic          start;
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [DW-1:0] fill_value;
    logic          busy;
    logic          done;
    logic [AW-1:0] address;
    logic [DW-1:0] in;
    logic          load;
    logic [DW-1:0] out;

    modport master (
        output start, mode, src, dst, len, fill_value, out,
        input  busy, done, address, in, load
    );

    modport slave (
        input  start, mode, src, dst, len, fill_value, out,
        output busy, done, address, in, load
    );
endinterface

// File: rtl/addr_counter.sv
// AW-bit address pointer: synchronous reset, parallel load, increment with natural wrap.
module addr_counter #(
    parameter int AW = hack_mem_pkg::AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] load_value,
    input  logic          inc,
    output logic [AW-1:0] value
);
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset)
            value <= '0;
        else if (load)
            value <= load_value;
        else if (inc)
            value <= value + 1'b1;
    end
endmodule

// File: rtl/mem_block_mover.sv
// Copy/fill engine for a RAM with combinational read: copy alternates READ/WRITE, fill writes every cycle.
module mem_block_mover
    import hack_mem_pkg::*;
#(
    parameter int AW = hack_mem_pkg::AW,
    parameter int DW = hack_mem_pkg::DW
) (
    input  logic         clock,
    input  logic         reset,
    mem_block_mover_if.slave bus
);
    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    state_t        state_q, state_d;
    logic [AW:0]   count_q;
    logic [DW-1:0] buffer_q;
    logic [DW-1:0] fill_q;
    logic          mode_q;
    logic [AW-1:0] src_ptr, dst_ptr;
    logic [AW:0]   len_eff;
    logic          accept;
    logic          last;

    assign len_eff = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
    assign accept  = (state_q == IDLE) && bus.start;
    assign last    = (count_q == {{AW{1'b0}}, 1'b1});

    addr_counter #(.AW(AW)) u_src_ptr (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .load_value (bus.src),
        .inc        (state_q == WRITE),
        .value      (src_ptr)
    );

    addr_counter #(.AW(AW)) u_dst_ptr (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .load_value (bus.dst),
        .inc        ((state_q == WRITE) || (state_q == FILL)),
        .value      (dst_ptr)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.load    = 1'b0;
        bus.address = '0;
        bus.in      = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (len_eff == '0)
                        state_d = DONE;
                    else if (bus.mode)
                        state_d = FILL;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                bus.busy    = 1'b1;
                bus.address = src_ptr;
                state_d     = WRITE;
            end
            WRITE, FILL: begin
                bus.busy    = 1'b1;
                bus.load    = 1'b1;
                bus.address = dst_ptr;
                bus.in      = (state_q == FILL) ? fill_q : buffer_q;
                // A copy returns to READ for the next word; a fill stays in FILL.
                state_d     = last ? DONE : (mode_q ? FILL : READ);
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the word buffer is a plain register, not a RAM, so it is reset with the rest of the datapath.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= '0;
            buffer_q <= '0;
            fill_q   <= '0;
            mode_q   <= 1'b0;
        end else begin
            if (accept) begin
                count_q <= len_eff;
                fill_q  <= bus.fill_value;
                mode_q  <= bus.mode;
            end else if ((state_q == WRITE) || (state_q == FILL)) begin
                count_q <= count_q - 1'b1;
            end
            if (state_q == READ)
                buffer_q <= bus.out;
        end
    end
endmodule

// File: tb/tb_mem_block_mover.sv
// Randomised bench for mem_block_mover against a behavioural RAM model with word-level copy/fill semantics.
module tb_mem_block_mover;
    localparam int AW = 9;
    localparam int DW = 16;
    localparam int DEPTH = 512;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    logic [DW-1:0] ram   [DEPTH];
    logic [DW-1:0] ram_m [DEPTH];
    logic [AW-1:0] wr_log[$];

    mem_block_mover_if #(.AW(AW), .DW(DW)) bus ();

    mem_block_mover #(.AW(AW), .DW(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    assign bus.out = ram[bus.address];

    always @(posedge clock) begin
        if (bus.load) begin
            ram[bus.address] <= bus.in;
            wr_log.push_back(bus.address);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int ram_diffs();
        int bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (ram[i] !== ram_m[i]) bad++;
        return bad;
    endfunction

    // Reference: word-by-word ascending copy or fill on the model RAM, addresses wrap mod 512.
    task automatic model_op(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int n, input logic [DW-1:0] f, output logic [AW-1:0] addrs[$]);
        logic [AW-1:0] a_s, a_d;
        addrs.delete();
        for (int i = 0; i < n; i++) begin
            a_s = s + AW'(i);
            a_d = d + AW'(i);
            ram_m[a_d] = m ? f : ram_m[a_s];
            addrs.push_back(a_d);
        end
    endtask

    task automatic do_op(input string tag, input logic m, input logic [AW-1:0] s,
                         input logic [AW-1:0] d, input logic [AW:0] n, input logic [DW-1:0] f,
                         input bit hold);
        int n_eff, exp_edge, done_edge, loads, busys, bad;
        logic [AW-1:0] exp_addr[$];
        n_eff    = (n > AW'(0) && int'(n) > DEPTH) ? DEPTH : int'(n);
        exp_edge = n_eff * (m ? 1 : 2);
        model_op(m, s, d, n_eff, f, exp_addr);
        wr_log.delete();

        @(negedge clock);
        bus.start = 1'b1; bus.mode = m; bus.src = s; bus.dst = d; bus.len = n; bus.fill_value = f;
        @(posedge clock);
        @(negedge clock);
        if (!hold) bus.start = 1'b0;
        // Command inputs are latched at the start edge, so later changes must not matter.
        bus.src = AW'($urandom); bus.dst = AW'($urandom);
        bus.len = (AW+1)'($urandom); bus.fill_value = DW'($urandom); bus.mode = 1'($urandom);

        done_edge = -1; loads = 0; busys = 0;
        for (int k = 0; k <= 1100; k++) begin
            if (bus.done) begin
                done_edge = k;
                break;
            end
            if (bus.load) loads++;
            if (bus.busy) busys++;
            @(negedge clock);
        end
        check({tag, "_done_edge"}, done_edge, exp_edge);
        check({tag, "_load_cycles"}, loads, n_eff);
        check({tag, "_busy_cycles"}, busys, exp_edge);
        check({tag, "_busy_in_done"}, bus.busy, 1'b0);

        @(negedge clock);
        bus.start = 1'b0;
        check({tag, "_done_one_cycle"}, bus.done, 1'b0);
        check({tag, "_idle_load"}, bus.load, 1'b0);
        check({tag, "_idle_addr"}, bus.address, 0);
        @(negedge clock);
        check({tag, "_no_restart_busy"}, bus.busy, 1'b0);
        check({tag, "_no_second_done"}, bus.done, 1'b0);

        bad = ram_diffs();
        check({tag, "_ram_diff_words"}, bad, 0);
        check({tag, "_write_count"}, wr_log.size(), exp_addr.size());
        bad = 0;
        for (int i = 0; i < exp_addr.size() && i < wr_log.size(); i++)
            if (wr_log[i] !== exp_addr[i]) bad++;
        check({tag, "_write_order"}, bad, 0);
    endtask

    initial begin
        int seen_done;
        logic [AW-1:0] dummy[$];
        bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0;
        bus.len = '0; bus.fill_value = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] <= DW'($urandom);
        #1;
        for (int i = 0; i < DEPTH; i++) ram_m[i] = ram[i];

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_load", bus.load, 1'b0);
        check("rst_address", bus.address, 0);
        check("rst_in", bus.in, 0);
        reset = 1'b0;

        do_op("fill_beef", 1'b1, 9'd10, 9'd10, 10'd4, 16'hBEEF, 1'b0);
        for (int i = 10; i <= 13; i++) check("fill_beef_word", ram[i], 16'hBEEF);

        @(negedge clock);
        ram[0] <= 16'd1; ram[1] <= 16'd2; ram[2] <= 16'd3;
        ram_m[0] = 16'd1; ram_m[1] = 16'd2; ram_m[2] = 16'd3;
        do_op("copy_123", 1'b0, 9'd0, 9'd100, 10'd3, 16'h0, 1'b1);
        check("copy_123_w102", ram[102], 16'd3);

        do_op("fill_wrap", 1'b1, 9'd0, 9'd510, 10'd4, 16'h5A5A, 1'b0);
        do_op("len_zero", 1'b0, 9'd3, 9'd7, 10'd0, 16'h0, 1'b1);

        @(negedge clock);
        ram[0] <= 16'd7; ram_m[0] = 16'd7;
        do_op("overlap", 1'b0, 9'd0, 9'd1, 10'd3, 16'h0, 1'b0);
        check("overlap_w3", ram[3], 16'd7);

        do_op("fill_clamp", 1'b1, 9'd0, 9'($urandom), 10'd700, 16'hC1A0, 1'b0);
        do_op("copy_full_wrap", 1'b0, 9'd300, 9'd0, 10'd512, 16'h0, 1'b0);

        for (int t = 0; t < 8; t++)
            do_op("random", 1'($urandom), AW'($urandom), AW'($urandom),
                  (AW+1)'($urandom_range(0, 24)), DW'($urandom), 1'($urandom));

        // Abort a len=5 copy right after its second write.
        wr_log.delete();
        model_op(1'b0, 9'd20, 9'd200, 2, 16'h0, dummy);
        @(negedge clock);
        bus.start = 1'b1; bus.mode = 1'b0; bus.src = 9'd20; bus.dst = 9'd200; bus.len = 10'd5;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_load", bus.load, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_address", bus.address, 0);
        check("abort_in", bus.in, 0);
        reset = 1'b0;
        seen_done = 0;
        repeat (12) begin
            @(negedge clock);
            if (bus.done || bus.load) seen_done++;
        end
        check("abort_no_activity", seen_done, 0);
        check("abort_write_count", wr_log.size(), 2);
        check("abort_ram_diff_words", ram_diffs(), 0);

        do_op("after_abort", 1'b0, 9'd40, 9'd41, 10'd6, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_block_mover.md
MEM_BLOCK_MOVER -- requirements
Module: mem_block_mover

Interface
REQ-001 Parameter AW, default 9, SHALL set the RAM address width (RAM512 depth = 512 words).
REQ-002 Parameter DW, default 16, SHALL set the data word width.
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL request an operation; sampled only in IDLE.
REQ-006 mode  input  1  SHALL select the operation: 0 = copy, 1 = fill.
REQ-007 src  input  AW  SHALL give the copy source base address.
REQ-008 dst  input  AW  SHALL give the destination base address.
REQ-009 len  input  AW+1  SHALL give the word count, 0..512.
REQ-010 fill_value  input  DW  SHALL give the fill pattern.
REQ-011 busy  output  1  SHALL be high in READ, WRITE and FILL.
REQ-012 done  output  1  SHALL pulse high for exactly one cycle on completion.
REQ-013 address  output  AW  SHALL drive the RAM address.
REQ-014 in  output  DW  SHALL drive the RAM write data.
REQ-015 load  output  1  SHALL drive the RAM write enable.
REQ-016 out  input  DW  SHALL be the RAM read data, combinational from address in the same cycle.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, READ, WRITE, FILL and DONE.
REQ-018 IDLE with start=1 SHALL latch src, dst, len, mode and fill_value.
REQ-019 On that start: len=0 -> DONE; mode=0 -> READ; mode=1 -> FILL.
REQ-020 READ SHALL drive address=src_ptr and load=0, capture out into an internal buffer at the edge, then go to WRITE.
REQ-021 WRITE SHALL drive address=dst_ptr, in=buffer and load=1.
REQ-022 At the WRITE edge, count SHALL decrement and src_ptr/dst_ptr increment; next state is DONE if count was 1, else READ.
REQ-023 FILL SHALL drive address=dst_ptr, in=fill_value and load=1.
REQ-024 At the FILL edge, count SHALL decrement and dst_ptr increment; next state is DONE if count was 1, else FILL.
REQ-025 DONE SHALL assert done=1 and busy=0 for one cycle, then go to IDLE.
REQ-026 With the start accepted at edge E0, DONE SHALL be entered at edge E0 + N*(mode ? 1 : 2), N=len.
REQ-027 Pointers SHALL wrap modulo 2^AW (511+1 -> 0); len > 512 SHALL be clamped to 512.
REQ-028 Copy SHALL proceed in ascending order word by word; overlapping ranges give that defined result.
REQ-029 start outside IDLE, including in DONE, SHALL be ignored.
REQ-030 load SHALL be a decode of the state register only (WRITE or FILL), never combinational from inputs.
REQ-031 In IDLE and DONE: address=0, in=0, load=0.

Reset
REQ-032 reset=1 SHALL force IDLE at the next edge from any state, overriding start.
REQ-033 After reset: busy=0, done=0, load=0, address=0, in=0; buffer, pointers and count = 0.
REQ-034 Reset mid-operation SHALL abort with no further writes; words already written remain and no done pulse is issued.

Structure
REQ-035 The shared package hack_mem_pkg SHALL hold AW, DW and the state encoding constants.
REQ-036 The pointers SHALL use one sub-module, addr_counter (AW-bit, synchronous reset, load, inc), instantiated twice: src_ptr and dst_ptr.

Verification
REQ-037 Fill: mode=1, dst=10, len=4, fill_value=16'hBEEF -> load high 4 cycles at addresses 10..13; done entered at E0+4; RAM[10..13]=BEEF.
REQ-038 Copy: RAM[0..2]={1,2,3}, src=0, dst=100, len=3 -> alternating READ/WRITE; RAM[100..102]={1,2,3}; done at E0+6; busy high 6 cycles.
REQ-039 Wrap: fill dst=510, len=4 -> writes at 510, 511, 0, 1.
REQ-040 len=0 -> done at E0 with no load cycles; start asserted while busy -> ignored, no second done.
REQ-041 Reset after the second WRITE of a len=5 copy -> IDLE next edge, load=0, only 2 words copied, no done pulse.
REQ-042 Overlap: RAM[0]=7, copy src=0, dst=1, len=3 -> RAM[1..3]=7.
